// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared debounce default and counter sizing helper
package button_conditioner_pkg;
  localparam int DEBOUNCE_DEFAULT = 1_000_000;
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/button_conditioner_debounce.sv
// button_conditioner_debounce: 2-flop sync, counter debounce, rising-edge pulse
module button_conditioner_debounce
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      prev <= level;
      if (sync[1] == level) cnt <= '0;
      else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else cnt <= cnt + CW'(1);
    end
  assign rise = level & ~prev;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: debounced RD/WR presses into gated FIFO strobes with drop flags
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] switch,
  input  logic       RD,
  input  logic       WR,
  input  logic       fifo_full,
  input  logic       fifo_empty,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       rd_en,
  output logic       wr_drop,
  output logic       rd_drop,
  output logic       rd_level,
  output logic       wr_level
);
  logic [7:0] sw_s0, sw_s1;
  logic rd_rise, wr_rise;
  button_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rd (
    .clk(clk), .rst_n(rst_n), .raw(RD), .level(rd_level), .rise(rd_rise)
  );
  button_conditioner_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_wr (
    .clk(clk), .rst_n(rst_n), .raw(WR), .level(wr_level), .rise(wr_rise)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sw_s0   <= '0;
      sw_s1   <= '0;
      wr_en   <= 1'b0;
      wr_drop <= 1'b0;
      rd_en   <= 1'b0;
      rd_drop <= 1'b0;
      wr_data <= '0;
    end else begin
      sw_s0   <= switch;
      sw_s1   <= sw_s0;
      wr_en   <= wr_rise & ~fifo_full;
      wr_drop <= wr_rise & fifo_full;
      rd_en   <= rd_rise & ~fifo_empty;
      rd_drop <= rd_rise & fifo_empty;
      if (wr_rise & ~fifo_full) wr_data <= sw_s1;
    end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce latency, gating and reset behaviour
module tb_button_conditioner;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] switch = '0;
  logic RD = 1'b0, WR = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b0;
  logic wr_en, rd_en, wr_drop, rd_drop, rd_level, wr_level;
  logic [7:0] wr_data;
  int vectors = 0, errs = 0;
  int n_wr = 0, n_rd = 0, n_wd = 0, n_rdd = 0;

  always #5 clk = ~clk;

  button_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .switch(switch), .RD(RD), .WR(WR),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .wr_en(wr_en),
    .wr_data(wr_data), .rd_en(rd_en), .wr_drop(wr_drop), .rd_drop(rd_drop),
    .rd_level(rd_level), .wr_level(wr_level)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_wr += int'(wr_en);
      n_rd += int'(rd_en);
      n_wd += int'(wr_drop);
      n_rdd += int'(rd_drop);
    end
  endtask

  task automatic clr();
    n_wr = 0; n_rd = 0; n_wd = 0; n_rdd = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(wr_en), 0);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_wr_drop"}, 32'(wr_drop), 0);
    chk({tag, "_rd_drop"}, 32'(rd_drop), 0);
    chk({tag, "_wr_data"}, 32'(wr_data), 0);
    chk({tag, "_levels"}, 32'({rd_level, wr_level}), 0);
  endtask

  initial begin
    tick(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    switch = 8'hA5;
    tick(3);
    // clean write press
    clr();
    WR = 1'b1;
    tick(5);
    chk("t1_level_e5", 32'(wr_level), 0);
    tick(1);
    chk("t1_level_e6", 32'(wr_level), 1);
    chk("t1_no_early_wr", 32'(n_wr), 0);
    tick(1);
    chk("t1_wr_en_e7", 32'(wr_en), 1);
    chk("t1_wr_data", 32'(wr_data), 32'hA5);
    chk("t1_others", 32'({rd_en, wr_drop, rd_drop}), 0);
    tick(1);
    chk("t1_wr_en_e8", 32'(wr_en), 0);
    WR = 1'b0;
    clr();
    tick(5);
    chk("t1_rel_level_e5", 32'(wr_level), 1);
    tick(1);
    chk("t1_rel_level_e6", 32'(wr_level), 0);
    tick(4);
    chk("t1_rel_no_pulse", 32'(n_wr + n_wd), 0);
    // write while full
    switch = 8'h3C;
    fifo_full = 1'b1;
    tick(3);
    clr();
    WR = 1'b1;
    tick(6);
    chk("full_no_early", 32'(n_wd + n_wr), 0);
    tick(1);
    chk("full_wr_drop", 32'(wr_drop), 1);
    chk("full_wr_en", 32'(wr_en), 0);
    chk("full_wr_data", 32'(wr_data), 32'hA5);
    tick(1);
    chk("full_drop_once", 32'(wr_drop), 0);
    WR = 1'b0;
    fifo_full = 1'b0;
    tick(10);
    // bouncing write press
    switch = 8'h5A;
    tick(3);
    clr();
    WR = 1'b1; tick(1);
    WR = 1'b0; tick(1);
    WR = 1'b1; tick(1);
    WR = 1'b0; tick(1);
    WR = 1'b1;
    tick(6);
    chk("bounce_no_early", 32'(n_wr), 0);
    tick(1);
    chk("bounce_wr_en", 32'(wr_en), 1);
    chk("bounce_wr_data", 32'(wr_data), 32'h5A);
    clr();
    tick(10);
    chk("bounce_single", 32'(n_wr), 0);
    WR = 1'b0;
    tick(10);
    // read while empty, then not empty
    fifo_empty = 1'b1;
    clr();
    RD = 1'b1;
    tick(6);
    chk("rd_empty_no_early", 32'(n_rdd + n_rd), 0);
    tick(1);
    chk("rd_drop", 32'(rd_drop), 1);
    chk("rd_drop_rd_en", 32'(rd_en), 0);
    tick(1);
    chk("rd_drop_once", 32'(rd_drop), 0);
    RD = 1'b0;
    tick(8);
    fifo_empty = 1'b0;
    clr();
    RD = 1'b1;
    tick(7);
    chk("rd_en", 32'(rd_en), 1);
    chk("rd_en_no_drop", 32'(n_rdd), 0);
    tick(1);
    chk("rd_en_once", 32'(rd_en), 0);
    RD = 1'b0;
    tick(8);
    // simultaneous presses
    switch = 8'hC3;
    tick(3);
    RD = 1'b1;
    WR = 1'b1;
    tick(7);
    chk("sim_both", 32'({rd_en, wr_en}), 32'h3);
    chk("sim_wr_data", 32'(wr_data), 32'hC3);
    tick(1);
    chk("sim_both_off", 32'({rd_en, wr_en}), 0);
    RD = 1'b0;
    WR = 1'b0;
    tick(8);
    // reset mid-count with button held through reset
    switch = 8'h96;
    tick(3);
    clr();
    WR = 1'b1;
    tick(4);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    tick(1);
    chk("midrst_no_strobe", 32'(n_wr), 0);
    rst_n = 1'b1;
    clr();
    tick(6);
    chk("post_rst_no_early", 32'(n_wr), 0);
    tick(1);
    chk("post_rst_wr_en", 32'(wr_en), 1);
    chk("post_rst_wr_data", 32'(wr_data), 32'h96);
    clr();
    tick(20);
    chk("hold_no_second", 32'(n_wr), 0);
    WR = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage between the board's pushbuttons/slide switches and the UART TX FIFO plus its LED debug display. Synchronizes and debounces the RD and WR pushbuttons and converts each debounced press into a single-cycle FIFO strobe. On each write press it captures the synchronized switch byte as FIFO write data. Write strobes are gated by FIFO full and read strobes by FIFO empty, and each rejected press is flagged.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1_000_000: consecutive cycles a synchronized button must differ from its stable state before the stable state flips (10 ms at 100 MHz). Minimum value 2.

Ports:
- clk  input  1  system clock; all state on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- switch  input  8  raw slide switches; the byte to be written.
- RD  input  1  raw read pushbutton, active-high, asynchronous, bouncy.
- WR  input  1  raw write pushbutton, active-high, asynchronous, bouncy.
- fifo_full  input  1  FIFO full flag, synchronous to clk.
- fifo_empty  input  1  FIFO empty flag, synchronous to clk.
- wr_en  output  1  one-cycle FIFO write strobe.
- wr_data  output  8  byte captured at the last accepted write press.
- rd_en  output  1  one-cycle FIFO read strobe.
- wr_drop  output  1  one-cycle pulse: write press rejected because the FIFO was full.
- rd_drop  output  1  one-cycle pulse: read press rejected because the FIFO was empty.
- rd_level  output  1  debounced RD level; drives the debug LED stage.
- wr_level  output  1  debounced WR level; drives the debug LED stage.

## Operation
- Synchronization: RD, WR and all 8 switch bits each pass through a 2-flop synchronizer. Switches are not debounced, because the user sets them before pressing WR.
- Debounce, per button: holds a stable bit and a counter.
  - Each edge where the synchronized input equals stable: counter <= 0.
  - Each edge where they differ: if counter == DEBOUNCE_CYCLES-1, then stable <= synchronized input and counter <= 0. Otherwise counter increments.
  - Any single-cycle agreement during a bounce restarts the count.
- Press detection: registered rising edge of stable (stable & ~stable_prev). A release produces no strobe.
- Write press:
  - fifo_full low: wr_en = 1 for one cycle, and wr_data <= synchronized switch on the same edge.
  - fifo_full high: wr_drop = 1 for one cycle; wr_en stays 0; wr_data is unchanged.
- Read press:
  - fifo_empty low: rd_en = 1 for one cycle.
  - fifo_empty high: rd_drop = 1 for one cycle.
- Full and empty are sampled in the same cycle the press is detected. There is no retry and no queuing of rejected presses.
- Simultaneous RD and WR presses are handled independently; rd_en and wr_en may both assert in the same cycle.
- Holding a button produces exactly one strobe; the next strobe requires a debounced release followed by a debounced press.

## Timing
- Reset (rst_n low, asynchronous): every output = 0; wr_data = 8'h00; synchronizers, stable bits, stable_prev and counters = 0.
- Latency: raw button rising clean before edge 1, with N = DEBOUNCE_CYCLES:
  - synchronized output high after edge 2;
  - stable (and the rd_level/wr_level output) high after edge N+2;
  - strobe or drop high for the cycle following edge N+3 only.
- wr_data changes only on the edge that raises wr_en, and holds until the next accepted write.
- Release: the level outputs fall after edge N+2 from a clean release; no pulse is produced.
- Reset deasserted while a button is held: stable starts at 0, so the held button is treated as a fresh press and strobes after N+3 edges.
- Reset asserted mid-count: counters and pending edges are discarded and no strobe is emitted.

## Structure
- Shared package: a DEBOUNCE_CYCLES default constant and a width function (clog2 of DEBOUNCE_CYCLES) used for counter sizing.
- Sub-module `debounce`: 2-flop synchronizer, counter and stable bit, rising-edge pulse output. It is instantiated twice (RD, WR) with DEBOUNCE_CYCLES passed through.
- The top level holds the switch synchronizer, the wr_data register, full/empty gating and the drop pulses.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- Clean WR press, switch = 8'hA5, fifo_full = 0 -> wr_level high after edge 6, wr_en high exactly one cycle after edge 7, wr_data = 8'hA5 thereafter. rd_en, wr_drop and rd_drop stay 0.
- WR bounces 1-0-1-0 at one-cycle spacing, then held high -> no wr_en during the bounce; exactly one wr_en, 7 edges after the final rising transition.
- RD press with fifo_empty = 1 -> rd_drop one cycle, rd_en 0. Repeat with fifo_empty = 0 -> rd_en one cycle.
- WR press with fifo_full = 1 and switch = 8'h3C after a prior accepted 8'hA5 -> wr_drop one cycle, wr_en 0, wr_data remains 8'hA5.
- RD and WR pressed on the same edge, FIFO neither full nor empty -> rd_en and wr_en high in the same single cycle.
- rst_n pulsed low mid-debounce (counter = 2), button held through reset -> all outputs 0 during reset; after release, exactly one strobe 7 edges later; a 20-cycle hold yields no second strobe.
